serial_tx: RTL and testbench

//   Framed bit-serial transmitter: accepts a parallel word on a valid/ready

---
 rtl/serial_tx.sv | 199 +++++++++++++++++++
 tb/tb_serial_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: framed bit-serial transmitter.
// A word accepted on the valid/ready handshake goes out on txd as one start
// bit (0), then WIDTH data bits LSB first, then an optional even-parity bit,
// then STOP_BITS stop bits (1). Every serial bit is held for CLKS_PER_BIT
// clocks. txd, busy and frames_sent come straight from flops. tx_ready is
// decoded from registered state, so a new word can be accepted on the edge
// that closes the last stop bit and the next frame follows with no idle gap.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    output logic             busy,
    output logic [7:0]       frames_sent
);

    // Cycle counter spans 0..CLKS_PER_BIT-1. The bit counter indexes data bits
    // and stop bits; STOP_BITS is at most 2, so one bit is always enough for the
    // stop index.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t           state_r, state_s;
    logic [CW-1:0]    cyc_r, cyc_s;
    logic [BW-1:0]    bit_r, bit_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic             par_r, par_s;
    logic             txd_r, txd_s;
    logic             busy_r, busy_s;
    logic [7:0]       frames_r, frames_s;

    logic             bit_end_s;
    logic             frame_end_s;
    logic             tx_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] shift_adv_s;

    assign bit_end_s   = (cyc_r == CYC_LAST);
    assign frame_end_s = (state_r == S_STOP) && bit_end_s && (bit_r == STOP_LAST);
    assign tx_ready_s  = (state_r == S_IDLE) || frame_end_s;
    assign accept_s    = tx_valid && tx_ready_s;
    // The shift register keeps the bit on the wire at position 0.
    assign shift_adv_s = shift_r >> 1;

    assign tx_ready    = tx_ready_s;
    assign txd         = txd_r;
    assign busy        = busy_r;
    assign frames_sent = frames_r;

    // Next-state, counter, shift register and next-txd logic of the framing FSM.
    always_comb begin
        state_s  = state_r;
        cyc_s    = cyc_r;
        bit_s    = bit_r;
        shift_s  = shift_r;
        par_s    = par_r;
        txd_s    = txd_r;
        frames_s = frames_r;
        case (state_r)
            S_IDLE: begin
                txd_s = 1'b1;
                if (accept_s) begin
                    state_s = S_START;
                    cyc_s   = {CW{1'b0}};
                    bit_s   = {BW{1'b0}};
                    shift_s = tx_data;
                    par_s   = even_parity(tx_data);
                    txd_s   = 1'b0;
                end else begin
                    cyc_s = {CW{1'b0}};
                    bit_s = {BW{1'b0}};
                end
            end
            S_START: begin
                txd_s = 1'b0;
                if (bit_end_s) begin
                    state_s = S_DATA;
                    cyc_s   = {CW{1'b0}};
                    bit_s   = {BW{1'b0}};
                    txd_s   = shift_r[0];
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
            S_DATA: begin
                txd_s = shift_r[0];
                if (bit_end_s) begin
                    cyc_s = {CW{1'b0}};
                    if (bit_r == DATA_LAST) begin
                        bit_s = {BW{1'b0}};
                        if (PARITY_EN != 0) begin
                            state_s = S_PARITY;
                            txd_s   = par_r;
                        end else begin
                            state_s = S_STOP;
                            txd_s   = 1'b1;
                        end
                    end else begin
                        bit_s   = bit_r + BW'(1);
                        shift_s = shift_adv_s;
                        txd_s   = shift_adv_s[0];
                    end
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
            S_PARITY: begin
                txd_s = par_r;
                if (bit_end_s) begin
                    state_s = S_STOP;
                    cyc_s   = {CW{1'b0}};
                    bit_s   = {BW{1'b0}};
                    txd_s   = 1'b1;
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
            S_STOP: begin
                txd_s = 1'b1;
                if (bit_end_s) begin
                    cyc_s = {CW{1'b0}};
                    if (bit_r == STOP_LAST) begin
                        // Frame closes on this edge; a waiting word starts at once.
                        frames_s = frames_r + 8'd1;
                        bit_s    = {BW{1'b0}};
                        if (accept_s) begin
                            state_s = S_START;
                            shift_s = tx_data;
                            par_s   = even_parity(tx_data);
                            txd_s   = 1'b0;
                        end else begin
                            state_s = S_IDLE;
                            txd_s   = 1'b1;
                        end
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cyc_s   = {CW{1'b0}};
                bit_s   = {BW{1'b0}};
                txd_s   = 1'b1;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State, datapath and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cyc_r    <= {CW{1'b0}};
            bit_r    <= {BW{1'b0}};
            shift_r  <= {WIDTH{1'b0}};
            par_r    <= 1'b0;
            txd_r    <= 1'b1;
            busy_r   <= 1'b0;
            frames_r <= 8'd0;
        end else begin
            state_r  <= state_s;
            cyc_r    <= cyc_s;
            bit_r    <= bit_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            txd_r    <= txd_s;
            busy_r   <= busy_s;
            frames_r <= frames_s;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx.
// dut0 uses the default parameters. dut1 adds even parity and two stop bits.
// One shared data bus feeds both instances, and tx_valid is routed to the
// instance chosen by sel. The expected txd level comes from the frame layout:
// the bit index is the cycle number divided by CLKS_PER_BIT.
module tb_serial_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       valid;
    logic       sel;

    logic       tx_valid0, tx_valid1;
    logic       tx_ready0, tx_ready1;
    logic       txd0, txd1;
    logic       busy0, busy1;
    logic [7:0] fs0, fs1;

    logic       obs_txd, obs_busy, obs_ready;
    logic [7:0] obs_fs;

    int total = 0;
    int bad   = 0;
    int exp_frames [2];

    assign tx_valid0 = valid & ~sel;
    assign tx_valid1 = valid & sel;
    assign obs_txd   = sel ? txd1 : txd0;
    assign obs_busy  = sel ? busy1 : busy0;
    assign obs_ready = sel ? tx_ready1 : tx_ready0;
    assign obs_fs    = sel ? fs1 : fs0;

    serial_tx dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .txd(txd0), .busy(busy0), .frames_sent(fs0)
    );

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .txd(txd1), .busy(busy1), .frames_sent(fs1)
    );

    always #5 clk = ~clk;

    // Frame length in clocks for the selected instance.
    function automatic int frame_len(input logic s);
        return (s ? 12 : 10) * CPB;
    endfunction

    // Serial bit number pos of the frame carrying d.
    function automatic logic model_bit(input logic [7:0] d, input int pos, input logic s);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[pos-1];
        if (pos == 9 && s) return ^d;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake one word into the selected instance, then scramble the bus.
    task automatic start(input logic [7:0] d);
        tx_data = d;
        valid   = 1'b1;
        total++;
        if (obs_ready !== 1'b1) begin
            $display("FAIL accept_ready got=%b want=1 t=%0t", obs_ready, $time);
            bad++;
        end
        step();
        valid   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    // Check every cycle of a frame that has already been accepted.
    task automatic body(input logic [7:0] d, input bit noise, input bit chain, input logic [7:0] nd);
        int fl;
        logic e;
        fl = frame_len(sel);
        for (int k = 0; k < fl; k++) begin
            e = model_bit(d, k / CPB, sel);
            total++;
            if (obs_txd !== e) begin
                $display("FAIL txd data=%h cyc=%0d got=%b want=%b", d, k, obs_txd, e);
                bad++;
            end
            total++;
            if (obs_busy !== 1'b1) begin
                $display("FAIL busy cyc=%0d got=%b want=1", k, obs_busy);
                bad++;
            end
            total++;
            if (obs_ready !== (k == fl - 1)) begin
                $display("FAIL tx_ready cyc=%0d got=%b want=%b", k, obs_ready, (k == fl - 1));
                bad++;
            end
            if (k == fl - 1) begin
                valid = chain;
                if (chain) tx_data = nd;
            end else if (noise) begin
                valid   = 1'($urandom_range(0, 1));
                tx_data = 8'($urandom);
            end
            step();
        end
        valid = 1'b0;
        exp_frames[sel] = (exp_frames[sel] + 1) % 256;
        total++;
        if (obs_fs !== 8'(exp_frames[sel])) begin
            $display("FAIL frames_sent got=%0d want=%0d", obs_fs, exp_frames[sel]);
            bad++;
        end
        if (!chain) begin
            total++;
            if (obs_txd !== 1'b1 || obs_busy !== 1'b0 || obs_ready !== 1'b1) begin
                $display("FAIL idle_after txd=%b busy=%b ready=%b want 1/0/1", obs_txd, obs_busy, obs_ready);
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; sel = 1'b0; tx_data = 8'h00;
        #3;
        total++;
        if (txd0 !== 1'b1 || tx_ready0 !== 1'b1 || busy0 !== 1'b0 || fs0 !== 8'd0) begin
            $display("FAIL reset_state txd=%b ready=%b busy=%b fs=%0d", txd0, tx_ready0, busy0, fs0);
            bad++;
        end
        #4 rst = 1'b0;
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        step();
    endtask

    task automatic test_single();
        sel = 1'b0;
        start(8'hA5);
        body(8'hA5, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        start(8'h00);
        body(8'h00, 1'b0, 1'b1, 8'hFF);
        body(8'hFF, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_parity();
        sel = 1'b1;
        start(8'h07);
        body(8'h07, 1'b0, 1'b0, 8'h00);
        start(8'h03);
        body(8'h03, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            start(d);
            body(d, 1'b1, 1'b0, 8'h00);
        end
        sel = 1'b0;
    endtask

    task automatic test_busy_ignore();
        sel = 1'b0;
        start(8'h3C);
        body(8'h3C, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            start(d);
            body(d, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_reset_midframe();
        sel = 1'b0;
        start(8'h96);
        for (int i = 0; i < 9; i++) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (txd0 !== 1'b1 || busy0 !== 1'b0 || tx_ready0 !== 1'b1 || fs0 !== 8'd0) begin
            $display("FAIL midframe_reset txd=%b busy=%b ready=%b fs=%0d", txd0, busy0, tx_ready0, fs0);
            bad++;
        end
        #2 rst = 1'b0;
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        step();
        start(8'h5A);
        body(8'h5A, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_wrap();
        logic [7:0] d, nd;
        sel = 1'b0;
        d = 8'($urandom);
        start(d);
        for (int i = 0; i < 256; i++) begin
            nd = 8'($urandom);
            body(d, 1'b0, (i < 255), nd);
            d = nd;
        end
        total++;
        if (fs0 !== 8'd1) begin
            $display("FAIL wrap got=%0d want=1", fs0);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_busy_ignore();
        test_reset_midframe();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
